// File: rtl/dcache_ram.sv
// dcache_ram: behavioural data-side memory responder for the core's dcache port.
// It services one load or store at a time. A request is captured in IDLE and waits
// LATENCY cycles in WAIT. The access happens on the edge that enters RESP. RESP then
// pulses the matching valid for one cycle.
//
// Parameters: ADDR_W (word-index width, DEPTH = 2**ADDR_W words of 32 bits),
//             LATENCY (wait cycles, 0..15).
// Ports:
//   clk, rst                  clock, synchronous active-low reset
//   dcache_addr               byte address (word index addr[ADDR_W+1:2], lane addr[1:0])
//   dcache_wreq, dcache_rreq  level requests, held until the matching valid
//   dcache_wdata              right-aligned store data
//   dcache_byte_enable        right-aligned size mask (0001/0011/1111)
//   dcache_wvalid             store complete pulse
//   dcache_rdata              right-aligned load data, holds until the next load
//   dcache_rvalid             load data valid pulse
//   busy                      high in WAIT and RESP
//   misalign_err              only with DCACHE_MISALIGN_TRAP_EN: pulses with valid
//                             on a misaligned half/word access
// Optional feature macro: DCACHE_MISALIGN_TRAP_EN
module dcache_ram #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] dcache_addr,
    input  logic        dcache_wreq,
    input  logic        dcache_rreq,
    input  logic [31:0] dcache_wdata,
    input  logic [3:0]  dcache_byte_enable,
    output logic        dcache_wvalid,
    output logic [31:0] dcache_rdata,
    output logic        dcache_rvalid,
`ifdef DCACHE_MISALIGN_TRAP_EN
    output logic        misalign_err,
`endif
    output logic        busy
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [3:0] LAT_M1 = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       do_access;

    // Captured request
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        be_q;
    logic              store_q;

    logic [31:0] mem [DEPTH];

    logic req;
    assign req = dcache_wreq | dcache_rreq;

    // With LATENCY == 0 the access happens on the accepting edge, so the live
    // inputs are used in IDLE; in every other state only the captured copy counts.
    logic [ADDR_W+1:0] a_sel;
    logic [31:0]       wd_sel;
    logic [3:0]        be_sel;
    logic              store_sel;
    always_comb begin
        if (state == S_IDLE) begin
            a_sel     = dcache_addr[ADDR_W+1:0];
            wd_sel    = dcache_wdata;
            be_sel    = dcache_byte_enable;
            store_sel = dcache_wreq;     // store wins when both are high
        end else begin
            a_sel     = addr_q;
            wd_sel    = wdata_q;
            be_sel    = be_q;
            store_sel = store_q;
        end
    end

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic [4:0]        sh;
    logic [3:0]        mask;
    logic [31:0]       wsh;
    assign idx  = a_sel[ADDR_W+1:2];
    assign off  = a_sel[1:0];
    assign sh   = {off, 3'b000};
    assign mask = be_sel << off;     // lanes past byte 3 fall off the top
    assign wsh  = wd_sel << sh;

    // Address bits above the word index are ignored, so accesses wrap modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^dcache_addr[31:ADDR_W+2];

    logic mis;
`ifdef DCACHE_MISALIGN_TRAP_EN
    assign mis = ((be_sel == 4'b0011) && (off == 2'd3)) ||
                 ((be_sel == 4'b1111) && (off != 2'd0));
`else
    assign mis = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        do_access = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (LATENCY == 0) begin
                        state_nxt = S_RESP;
                        do_access = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                        cnt_nxt   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_nxt = S_RESP;
                    do_access = 1'b1;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            S_RESP:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            cnt           <= 4'd0;
            dcache_wvalid <= 1'b0;
            dcache_rvalid <= 1'b0;
            dcache_rdata  <= 32'd0;
            addr_q        <= '0;
            wdata_q       <= 32'd0;
            be_q          <= 4'd0;
            store_q       <= 1'b0;
        end else begin
            state         <= state_nxt;
            cnt           <= cnt_nxt;
            dcache_wvalid <= do_access && store_sel;
            dcache_rvalid <= do_access && !store_sel;
            if (do_access && !store_sel && !mis)
                dcache_rdata <= mem[idx] >> sh;
            if (state == S_IDLE && req) begin
                addr_q  <= dcache_addr[ADDR_W+1:0];
                wdata_q <= dcache_wdata;
                be_q    <= dcache_byte_enable;
                store_q <= dcache_wreq;
            end
        end
    end

`ifdef DCACHE_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (!rst) misalign_err <= 1'b0;
        else      misalign_err <= do_access && mis;
    end
`endif

    // RAM is not cleared by reset; a reset on the access edge drops the write.
    always_ff @(posedge clk) begin
        if (rst && do_access && store_sel && !mis) begin
            for (int b = 0; b < 4; b++)
                if (mask[b]) mem[idx][8*b +: 8] <= wsh[8*b +: 8];
        end
    end

    assign busy = (state != S_IDLE);

endmodule
